// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types: upstream read-data payload and default
// per-master credit depth.
package vector_cache_pkg;

  localparam int N_MASTERS            = 16;
  localparam int MASTER_ID_W          = $clog2(N_MASTERS);
  localparam int ROB_ID_W             = 6;
  localparam int DATA_W               = 32;
  localparam int DEFAULT_CREDIT_DEPTH = 4;

  typedef struct packed {
    logic [MASTER_ID_W-1:0] master_id;
    logic [ROB_ID_W-1:0]    rob_id;
  } txn_id_t;

  typedef struct packed {
    txn_id_t           txn_id;
    logic [DATA_W-1:0] data;
    logic              last;
  } us_data_pld_t;

endpackage

// File: rtl/vec_cache_sync_fifo.sv
// Generic register FIFO; push/pop are qualified internally so an ignored
// request never moves a pointer.
module vec_cache_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      occupancy,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign pop_ok    = pop && !empty;
  // A pop in the same edge frees the slot, so a full FIFO still accepts.
  assign push_ok   = push && (!full || pop_ok);
  assign occupancy = count;
  assign rd_data   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/vec_cache_rd_data_master_buf.sv
// Per-master read-data response buffer: absorbs beats from the decode lane,
// presents them over valid/ready and returns one credit per drained beat.
module vec_cache_rd_data_master_buf
  import vector_cache_pkg::*;
#(
  parameter  int N         = N_MASTERS,
  parameter  int MASTER_ID = 0,
  parameter  int DEPTH     = DEFAULT_CREDIT_DEPTH,
  localparam int OCC_W     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  us_data_pld_t     in_pld,
  output logic             out_vld,
  input  logic             out_rdy,
  output us_data_pld_t     out_pld,
  output logic             credit_rtn,
  output logic [OCC_W-1:0] occupancy,
  output logic             ovf_err,
  output logic             misroute_err
);

  localparam int PLD_W = $bits(us_data_pld_t);

  logic             full;
  logic             empty;
  logic             pop;
  logic             push;
  logic             misroute;
  logic [PLD_W-1:0] head;

  assign pop      = out_vld && out_rdy;
  assign push     = in_vld && (!full || pop);
  assign misroute = in_vld && (in_pld.txn_id.master_id != MASTER_ID_W'(MASTER_ID));
  assign out_vld  = !empty;
  assign out_pld  = us_data_pld_t'(head);

  vec_cache_sync_fifo #(
    .WIDTH (PLD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .wr_data   (in_pld),
    .pop       (pop),
    .rd_data   (head),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_rtn   <= 1'b0;
      ovf_err      <= 1'b0;
      misroute_err <= 1'b0;
    end else begin
      credit_rtn <= pop;
      if (in_vld && full && !pop) ovf_err      <= 1'b1;
      if (misroute)               misroute_err <= 1'b1;
    end
  end

  // Parameter sanity, evaluated whenever reset is applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (DEPTH >= 2 && (DEPTH & (DEPTH - 1)) == 0);
      assert (MASTER_ID >= 0 && MASTER_ID < N);
      assert ($clog2(N) <= MASTER_ID_W);
    end
  end

endmodule

// File: tb/tb_vec_cache_rd_data_master_buf.sv
// Randomized bench for the per-master read-data buffer against a queue model.
module tb_vec_cache_rd_data_master_buf;
  import vector_cache_pkg::*;

  localparam int DEPTH = 4;
  localparam int MID   = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_vld;
  us_data_pld_t in_pld;
  logic         out_vld;
  logic         out_rdy;
  us_data_pld_t out_pld;
  logic         credit_rtn;
  logic [2:0]   occupancy;
  logic         ovf_err;
  logic         misroute_err;

  int errors = 0;
  int checks = 0;

  us_data_pld_t m_q[$];
  bit           m_ovf, m_mis, m_crd;

  vec_cache_rd_data_master_buf #(.N(16), .MASTER_ID(MID), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_pld(in_pld), .out_vld(out_vld),
    .out_rdy(out_rdy), .out_pld(out_pld), .credit_rtn(credit_rtn),
    .occupancy(occupancy), .ovf_err(ovf_err), .misroute_err(misroute_err)
  );

  always #5 clk = ~clk;

  function automatic us_data_pld_t mk(input logic [3:0] mid);
    us_data_pld_t p;
    p.txn_id.master_id = mid;
    p.txn_id.rob_id    = 6'($urandom);
    p.data             = $urandom;
    p.last             = 1'($urandom);
    return p;
  endfunction

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic cyc(input logic v, input us_data_pld_t p, input logic r);
    bit pop_m, full_m;
    in_vld  = v;
    in_pld  = p;
    out_rdy = r;
    pop_m  = (m_q.size() != 0) && r;
    full_m = (m_q.size() == DEPTH);
    if (v && p.txn_id.master_id != 4'(MID)) m_mis = 1;
    if (v && full_m && !pop_m) m_ovf = 1;
    if (pop_m) void'(m_q.pop_front());
    if (v && (!full_m || pop_m)) m_q.push_back(p);
    m_crd = pop_m;
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic do_reset(input logic r);
    rst = 1'b1; in_vld = 1'b0; in_pld = '0; out_rdy = r;
    @(posedge clk); #1;
    rst = 1'b0; out_rdy = 1'b0;
    m_q.delete(); m_ovf = 0; m_mis = 0; m_crd = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_vld = 1'b0; in_pld = '0; out_rdy = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    m_q.delete(); m_ovf = 0; m_mis = 0; m_crd = 0;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", out_vld); end
    checks++; if (out_pld !== us_data_pld_t'('0)) begin errors++; $display("FAIL reset_pld got=%h exp=0", out_pld); end
    checks++; if (credit_rtn !== 1'b0) begin errors++; $display("FAIL reset_crd got=%b exp=0", credit_rtn); end
    checks++; if ({ovf_err, misroute_err} !== 2'b00) begin errors++; $display("FAIL reset_err got=%b exp=00", {ovf_err, misroute_err}); end
  endtask

  task automatic test_fill_drain();
    us_data_pld_t sent[4];
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      sent[i] = mk(4'(MID));
      cyc(1'b1, sent[i], 1'b0);
      checks++; if (occupancy !== 3'(i + 1)) begin errors++; $display("FAIL fill_occ i=%0d got=%0d exp=%0d", i, occupancy, i + 1); end
      checks++; if (out_pld !== sent[0]) begin errors++; $display("FAIL fill_head i=%0d got=%h exp=%h", i, out_pld, sent[0]); end
    end
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4) begin
        checks++; if (out_pld !== sent[k-1] || out_vld !== 1'b1) begin errors++; $display("FAIL drain_pld k=%0d got=%h exp=%h", k, out_pld, sent[k-1]); end
      end
      cyc(1'b0, '0, 1'b1);
      checks++; if (credit_rtn !== (k <= 4)) begin errors++; $display("FAIL drain_crd k=%0d got=%b exp=%b", k, credit_rtn, k <= 4); end
      checks++; if (occupancy !== 3'((k <= 4) ? 4 - k : 0)) begin errors++; $display("FAIL drain_occ k=%0d got=%0d", k, occupancy); end
    end
  endtask

  task automatic test_latency();
    us_data_pld_t p;
    do_reset(1'b0);
    p = mk(4'(MID));
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL lat_vld_T got=%b exp=0", out_vld); end
    cyc(1'b1, p, 1'b1);
    checks++; if (out_vld !== 1'b1 || out_pld !== p) begin errors++; $display("FAIL lat_vld_T1 got=%b/%h exp=1/%h", out_vld, out_pld, p); end
    checks++; if (credit_rtn !== 1'b0) begin errors++; $display("FAIL lat_crd_T1 got=%b exp=0", credit_rtn); end
    cyc(1'b0, '0, 1'b1);
    checks++; if (credit_rtn !== 1'b1 || out_vld !== 1'b0) begin errors++; $display("FAIL lat_crd_T2 got=%b/%b exp=1/0", credit_rtn, out_vld); end
    cyc(1'b0, '0, 1'b1);
    checks++; if (credit_rtn !== 1'b0) begin errors++; $display("FAIL lat_crd_T3 got=%b exp=0", credit_rtn); end
  endtask

  task automatic test_full_push_pop();
    us_data_pld_t sent[$];
    us_data_pld_t got[$];
    us_data_pld_t p;
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      p = mk(4'(MID)); sent.push_back(p); cyc(1'b1, p, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      p = mk(4'(MID)); sent.push_back(p);
      got.push_back(out_pld);
      cyc(1'b1, p, 1'b1);
      checks++; if (occupancy !== 3'd4 || ovf_err !== 1'b0) begin errors++; $display("FAIL full_pp i=%0d occ=%0d ovf=%b exp=4/0", i, occupancy, ovf_err); end
    end
    for (int i = 0; i < 4; i++) begin
      got.push_back(out_pld);
      cyc(1'b0, '0, 1'b1);
    end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL full_pp_end occ=%0d exp=0", occupancy); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (got[i] !== sent[i]) begin errors++; $display("FAIL full_pp_order i=%0d got=%h exp=%h", i, got[i], sent[i]); end
    end
  endtask

  task automatic test_overflow();
    us_data_pld_t sent[4];
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin sent[i] = mk(4'(MID)); cyc(1'b1, sent[i], 1'b0); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_pre got=%b exp=0", ovf_err); end
    cyc(1'b1, mk(4'(MID)), 1'b0);
    checks++; if (ovf_err !== 1'b1 || occupancy !== 3'd4) begin errors++; $display("FAIL ovf_set ovf=%b occ=%0d exp=1/4", ovf_err, occupancy); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_pld !== sent[i]) begin errors++; $display("FAIL ovf_contents i=%0d got=%h exp=%h", i, out_pld, sent[i]); end
      cyc(1'b0, '0, 1'b1);
    end
    checks++; if (ovf_err !== 1'b1 || out_vld !== 1'b0) begin errors++; $display("FAIL ovf_sticky ovf=%b vld=%b exp=1/0", ovf_err, out_vld); end
  endtask

  task automatic test_misroute();
    do_reset(1'b0);
    cyc(1'b1, mk(4'd5), 1'b0);
    checks++; if (misroute_err !== 1'b1 || occupancy !== 3'd1) begin errors++; $display("FAIL mis_set mis=%b occ=%0d exp=1/1", misroute_err, occupancy); end
    cyc(1'b1, mk(4'(MID)), 1'b0);
    checks++; if (misroute_err !== 1'b1 || occupancy !== 3'd2) begin errors++; $display("FAIL mis_sticky mis=%b occ=%0d exp=1/2", misroute_err, occupancy); end
  endtask

  task automatic test_reset_mid();
    us_data_pld_t p;
    do_reset(1'b0);
    cyc(1'b1, mk(4'd5), 1'b0);
    cyc(1'b1, mk(4'(MID)), 1'b0);
    cyc(1'b1, mk(4'(MID)), 1'b0);
    cyc(1'b1, mk(4'(MID)), 1'b1);
    checks++; if (occupancy !== 3'd3 || credit_rtn !== 1'b1) begin errors++; $display("FAIL rmid_pre occ=%0d crd=%b exp=3/1", occupancy, credit_rtn); end
    do_reset(1'b1);
    checks++; if (occupancy !== 3'd0 || out_vld !== 1'b0 || credit_rtn !== 1'b0) begin errors++; $display("FAIL rmid_state occ=%0d vld=%b crd=%b exp=0/0/0", occupancy, out_vld, credit_rtn); end
    checks++; if ({ovf_err, misroute_err} !== 2'b00) begin errors++; $display("FAIL rmid_err got=%b exp=00", {ovf_err, misroute_err}); end
    p = mk(4'(MID));
    cyc(1'b1, p, 1'b0);
    checks++; if (out_pld !== p || occupancy !== 3'd1) begin errors++; $display("FAIL rmid_first got=%h occ=%0d exp=%h/1", out_pld, occupancy, p); end
    cyc(1'b0, '0, 1'b1);
    checks++; if (credit_rtn !== 1'b1 || occupancy !== 3'd0) begin errors++; $display("FAIL rmid_pop crd=%b occ=%0d exp=1/0", credit_rtn, occupancy); end
  endtask

  task automatic test_random();
    logic [3:0] mid;
    do_reset(1'b0);
    for (int i = 0; i < 400; i++) begin
      mid = ($urandom_range(0, 31) == 0) ? 4'($urandom) : 4'(MID);
      cyc(1'($urandom_range(0, 3) != 0), mk(mid), 1'($urandom_range(0, 2) != 0));
      checks++; if (occupancy !== 3'(m_q.size())) begin errors++; $display("FAIL rnd_occ i=%0d got=%0d exp=%0d", i, occupancy, m_q.size()); end
      checks++; if (out_vld !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_vld i=%0d got=%b", i, out_vld); end
      if (m_q.size() != 0) begin
        checks++; if (out_pld !== m_q[0]) begin errors++; $display("FAIL rnd_pld i=%0d got=%h exp=%h", i, out_pld, m_q[0]); end
      end
      checks++; if (credit_rtn !== m_crd) begin errors++; $display("FAIL rnd_crd i=%0d got=%b exp=%b", i, credit_rtn, m_crd); end
      checks++; if ({ovf_err, misroute_err} !== {m_ovf, m_mis}) begin errors++; $display("FAIL rnd_err i=%0d got=%b exp=%b", i, {ovf_err, misroute_err}, {m_ovf, m_mis}); end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_latency();
    test_full_push_pop();
    test_overflow();
    test_misroute();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vec_cache_rd_data_master_buf.md
Name: vec_cache_rd_data_master_buf

Overview:
- Per-master read-data response buffer, one instance per master port.
- Sits directly downstream of the read-data master decode crossbar and takes one of its N out_vld/out_pld lanes.
- The decode stage has no backpressure, so this block absorbs beats in a FIFO and presents them to the master over valid/ready.
- It returns one credit upstream per beat drained, so the upstream scheduler never issues more than DEPTH outstanding beats to this master.

Parameters:
- N, 16, number of master ports; sets master_id width $clog2(N).
- MASTER_ID, 0, index of the master this instance serves; range 0..N-1.
- DEPTH, 4, FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- in_vld  input  1  beat from the decode lane; no ready, always accepted if space.
- in_pld  input  us_data_pld_t  beat payload; carries txn_id.master_id.
- out_vld  output  1  head entry valid toward master.
- out_rdy  input  1  master accepts the head.
- out_pld  output  us_data_pld_t  head entry payload.
- credit_rtn  output  1  one-cycle pulse per popped entry, to the upstream credit counter.
- occupancy  output  $clog2(DEPTH)+1  current entry count.
- ovf_err  output  1  sticky: a beat arrived while full with no pop.
- misroute_err  output  1  sticky: a beat arrived with master_id != MASTER_ID.

Behaviour:
- Reset (rst=1 at a clk edge):
  - wr_ptr, rd_ptr and occupancy go to 0.
  - out_vld, credit_rtn, ovf_err and misroute_err go to 0.
  - out_pld is not constrained while out_vld=0; the implementation drives '0.
  - Storage contents are not reset.
- Push and pop conditions:
  - push = in_vld && (occupancy<DEPTH || pop).
  - pop = out_vld && out_rdy.
- Latency:
  - A beat pushed in cycle T appears at out_vld/out_pld in cycle T+1 at the earliest.
  - There is no same-cycle bypass from in to out.
- Ordering: strict FIFO; the head is stable while out_vld=1 && out_rdy=0.
- out_vld = (occupancy != 0), decoded from registered state.
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - When full, the push is accepted because the pop frees the slot in the same edge.
- Overflow:
  - Condition: in_vld && occupancy==DEPTH && !pop.
  - The beat is dropped and ovf_err is set on the next edge.
  - Pointers do not move.
  - This is a protocol violation; upstream credits should prevent it.
- Misroute:
  - Condition: in_vld && in_pld.txn_id.master_id != MASTER_ID.
  - misroute_err is set.
  - The beat is still pushed if there is space; this is a debug aid, not a filter.
- Error flags: ovf_err and misroute_err are sticky until rst.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - occupancy is tracked separately, with range 0..DEPTH inclusive.
- credit_rtn:
  - Registered: credit_rtn = pop delayed by one cycle.
  - It pulses 1 for exactly one cycle per popped beat.
  - Back-to-back pops give back-to-back pulses.
- Empty: out_rdy while empty has no effect and no credit is returned.
- Reset mid-operation:
  - Contents are discarded and no credits are returned for them.
  - The upstream credit counter is reset by the same rst.
- Reset-time assertions (simulation only):
  - DEPTH is a power of 2 and at least 2.
  - MASTER_ID < N.

Decomposition:
- Shared package vector_cache_pkg holds:
  - us_data_pld_t, including txn_id.master_id.
  - A constant for the default per-master credit depth, equal to DEPTH.
- Natural sub-module vec_cache_sync_fifo:
  - Generic WIDTH/DEPTH register FIFO with push, pop, occupancy, full and empty.
  - Synchronous active-high rst.
- The top level adds the misroute check, the overflow flag and the credit pulse.

Test Plan:
- Fill then drain:
  - Stimulus: DEPTH=4; push 4 beats on consecutive cycles with out_rdy=0, then hold out_rdy=1.
  - Required: occupancy reaches 4 and out_pld equals the head until out_rdy rises.
  - Required: 4 ordered pops, credit_rtn high for 4 consecutive cycles starting one cycle after the first pop, and occupancy back to 0.
- Push in cycle T with out_rdy=1 and FIFO empty:
  - out_vld is 0 in cycle T and 1 in T+1.
  - Pop occurs in T+1; credit_rtn pulses in T+2.
- Full with simultaneous push and pop:
  - occupancy stays 4 and the new beat is accepted.
  - ovf_err stays 0.
  - Order is preserved across 8 total beats.
- Overflow:
  - Stimulus: occupancy=4, out_rdy=0, in_vld=1.
  - Required: the beat is dropped, ovf_err=1 from the next cycle and stays 1.
  - Required: the FIFO contents are unchanged.
- Misroute:
  - Stimulus: MASTER_ID=3, beat with master_id=5.
  - Required: misroute_err=1 and occupancy increments.
  - Required: a subsequent correct beat does not clear misroute_err.
- Reset mid-operation:
  - Stimulus: occupancy=3, rst=1 for one cycle.
  - Required: next cycle has occupancy=0, out_vld=0, credit_rtn=0, and both error flags 0.
  - Required: the next pushed beat emerges first.
